// File: rtl/fp_unit_arbiter.sv
// Arbitrates NREQ requesters onto one shared, fixed-latency pipelined FP unit and routes results back.
// Define FP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default is round-robin.
module fp_unit_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  input  logic [WIDTH-1:0]      op_res,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [CNT_W-1:0]      issue_cnt
);
  localparam int unsigned IDX_W = $clog2(NREQ);

  logic             issue;
  logic [IDX_W-1:0] gidx;
  logic [NREQ-1:0]  grant;

`ifdef FP_ARB_FIXED_PRIO_EN
  always_comb begin
    issue = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!issue && req_valid[i]) begin
        issue = 1'b1;
        gidx  = IDX_W'(i);
      end
    end
    if (issue) grant[gidx] = 1'b1;
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search starts at ptr and wraps; modulo keeps non-power-of-two NREQ in range.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    issue = 1'b0;
    gidx  = '0;
    grant = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr_q) + off) % NREQ;
      if (!issue && req_valid[idx]) begin
        issue = 1'b1;
        gidx  = IDX_W'(idx);
      end
    end
    if (issue) grant[gidx] = 1'b1;
    ptr_d = ptr_q;
    if (issue) ptr_d = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign req_ready = grant;
  assign op_a      = issue ? req_a[32'(gidx)*WIDTH +: WIDTH] : '0;
  assign op_b      = issue ? req_b[32'(gidx)*WIDTH +: WIDTH] : '0;

  logic [LATENCY-1:0]            tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
  logic [CNT_W-1:0]              issue_cnt_q, issue_cnt_d;

  // Tag pipeline mirrors the unit latency; bubbles enter as valid=0.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = issue;
    tag_idx_d[0] = gidx;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    issue_cnt_d = issue_cnt_q + CNT_W'(issue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      issue_cnt_q <= '0;
    end else begin
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_vld_q[LATENCY-1]) begin
      rsp_valid[tag_idx_q[LATENCY-1]] = 1'b1;
      rsp_data                        = op_res;
    end
  end

  assign issue_cnt = issue_cnt_q;
endmodule

// File: doc/fp_unit_arbiter.md
# fp_unit_arbiter

Shares one pipelined floating-point unit (Add or Mul, non-stalling, fixed latency) among `NREQ` requesters. Each cycle it grants at most one valid requester, drives that requester's operands into the unit, and carries the requester index through a tag pipeline matched to the unit latency. It then returns each result to the requester that issued it. It sits between the compute-lane request logic and a single shared Add/Mul instance.

## Interface
- `WIDTH`, 32: operand/result width (IEEE 754 single).
- `NREQ`, 4: number of requesters, 2..16.
- `LATENCY`, 2: cycles from operands on `op_a`/`op_b` to the result on `op_res`; must equal the attached unit's latency, ≥1.
- `CNT_W`, 16: width of the issue counter.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: requester i has an operation pending.
- `req_a` in NREQ*WIDTH: operand a, requester i at bits [i*WIDTH +: WIDTH].
- `req_b` in NREQ*WIDTH: operand b, same packing.
- `req_ready` out NREQ: one-hot-or-zero grant; the op of requester i is issued in a cycle where `req_valid[i] && req_ready[i]`.
- `op_a`, `op_b` out WIDTH: operands to the shared unit.
- `op_res` in WIDTH: result from the shared unit.
- `rsp_valid` out NREQ: one-hot-or-zero; result for requester i is on `rsp_data` this cycle.
- `rsp_data` out WIDTH: returned result.
- `issue_cnt` out CNT_W: number of issued operations, wraps.

## Operation
- Grant is combinational from `req_valid` and the round-robin pointer `ptr` (log2 NREQ bits).
- Search begins at index `ptr` and ascends with wrap; the first valid index wins.
- `req_ready` depends on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- After an issue by index g, `ptr <= (g+1) mod NREQ`. With no issue, `ptr` holds.
- `op_a`/`op_b` carry the granted operands in the issue cycle. They are 0 when nothing is granted.
- Tag pipeline: `LATENCY` stages of {valid, index}. Stage 0 loads {issue, g} every cycle, and a bubble is loaded as valid=0.
- `rsp_valid[idx] = tail.valid && tail.idx == idx`. `rsp_data = op_res` when the tail is valid, otherwise 0.
- There is no response backpressure. A requester must accept a response in the cycle it is presented.
- `issue_cnt` increments by 1 on each issue and wraps from 2^CNT_W−1 to 0.
- Requester operands need only be stable in the issue cycle; the attached unit registers them.

## Timing
- Reset (async assert, sync deassert by the integrator) sets:
  - `ptr = 0`
  - all tag stages valid=0
  - `issue_cnt = 0`
  - `rsp_valid = 0` and `rsp_data = 0`
- `req_ready`/`op_a`/`op_b` follow the reset state combinationally.
- Latency: an issue at cycle T gives `rsp_valid` at cycle T+LATENCY.
- Throughput: one issue per cycle, sustained.
- Results return in issue order and each carries exactly the issuing index.
- Single valid requester: it is granted every cycle regardless of `ptr`.
- All requesters valid: grants rotate `ptr`, `ptr+1`, … with wrap. Each requester receives one grant per NREQ cycles.
- Reset mid-operation: in-flight tags are discarded, and no `rsp_valid` occurs for operations issued before reset. Results the unit emits after reset are ignored.
- A response at the tail and an issue in the same cycle are independent, including when both belong to the same requester.

## Configuration
- `FP_ARB_FIXED_PRIO_EN` defined:
  - fixed priority; the lowest valid index always wins
  - `ptr` is not implemented
  - starvation of higher indices is permitted
- `FP_ARB_FIXED_PRIO_EN` undefined (default): round-robin as specified above.

## Test plan
- Reset, then `req_valid=4'b0001` with a=0x3F800000, b=0x40000000 for one cycle. Expect:
  - `req_ready=0001` and `op_a=0x3F800000`
  - `rsp_valid=0001` exactly 2 cycles later with `rsp_data=op_res`
  - `issue_cnt=1`
- `req_valid=4'b1111` held for 8 cycles from reset. Expect:
  - grants 0,1,2,3,0,1,2,3
  - responses in the same order, offset by 2 cycles
  - `issue_cnt=8`
- `req_valid=4'b1010` after a grant to index 1 (`ptr=2`). Expect the next grant to go to 3, then 1. With `FP_ARB_FIXED_PRIO_EN`, expect 1 on every cycle.
- Back-to-back issues with bubbles: pattern issue/idle/issue. Expect `rsp_valid` pattern 1,0,1 with no response in the bubble cycle and `rsp_data=0` there.
- Assert `rst_n=0` one cycle after two issues, release after 1 cycle. Expect:
  - no `rsp_valid` afterwards
  - `issue_cnt=0` and `ptr=0`
- `CNT_W=4`, 17 issues. Expect `issue_cnt` to wrap to 1.
